sram_axi_bridge_mo: RTL and testbench
=====================================

# sram_axi_bridge_mo

Parametrised bridge from two SRAM-like masters to one AXI3 master port: an instruction port (reads only) and a data port (reads/writes). Up to `MAX_RD` reads outstanding per ID, with full-throughput AR issue and one outstanding write. Requests on the data port complete in order, and a read-after-write guard covers instruction fetches. It sits between the CPU core and the AXI crossbar.

## Interface
- `ADDR_W`, default 32: address width on both sides.
- `DATA_W`, default 32: data width; 32 or 64; strobe width is `DATA_W/8`.
- `MAX_RD`, default 4: maximum outstanding reads per ID (≥1); counter width is `$clog2(MAX_RD+1)`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_req`, `inst_wr`, `inst_size[2:0]`, `inst_wstrb[DATA_W/8]`, `inst_addr[ADDR_W]`, `inst_wdata[DATA_W]`  in: instruction SRAM-like request; `inst_wr`/`inst_wstrb`/`inst_wdata` are ignored.
- `inst_rdata`  out  DATA_W  read data, valid with `inst_data_ok`.
- `inst_addr_ok`  out  1  request accepted (combinational).
- `inst_data_ok`  out  1  one-cycle completion pulse.
- `data_req`, `data_wr`, `data_size[2:0]`, `data_wstrb`, `data_addr`, `data_wdata`  in: data SRAM-like request.
- `data_rdata` (out, DATA_W), `data_addr_ok` (out, 1), `data_data_ok` (out, 1): as for the instruction port.
- AR channel: `arid[3:0]`, `araddr`, `arlen[7:0]`=0, `arsize[2:0]`, `arburst`=01, `arlock`=0, `arcache`=0, `arprot`=0 as outputs; `arvalid` out; `arready` in.
- R channel: `rid`, `rdata`, `rresp`, `rlast`, `rvalid` in; `rready` out.
- AW channel: `awid`=1, `awaddr`, `awlen`=0, `awsize`, `awburst`=01, `awlock`/`awcache`/`awprot`=0 as outputs; `awvalid` out; `awready` in.
- W channel: `wid`=1, `wdata`, `wstrb`, `wlast`=1, `wvalid` as outputs; `wready` in.
- B channel: `bid`, `bresp`, `bvalid` in; `bready` out.

## Operation
- **IDs.** Instruction reads use ID 0 and data reads use ID 1; writes always use ID 1. `rresp` and `bresp` are ignored.
- **AR slot.** A single register holds `arid`, `araddr`, `arsize` and `arvalid`. It is free when `~arvalid | arready`.
- **`inst_addr_ok`** = `inst_req & ~inst_wr & slot_free & cnt0<MAX_RD & ~raw_hit & ~data_rd_win`.
- **`raw_hit`** = `wr_busy & (inst_addr[ADDR_W-1:2]==awaddr_q[ADDR_W-1:2])`. It blocks a fetch from a word being written.
- **Data read `addr_ok`** = `data_req & ~data_wr & slot_free & cnt1<MAX_RD & ~wr_busy`.
- **Data write `addr_ok`** = `data_req & data_wr & ~wr_busy & cnt1==0 & ~(arvalid & arid==1)`.
- **Data-port ordering.** A data read and a data write are never outstanding together, so data_ok order always equals request order.
- **Arbitration.** When both ports want a read in the same cycle, the data read wins (`data_rd_win`). A data write and an instruction read may be accepted in the same cycle.
- **Read accept.** The AR slot is loaded on the next edge with `arvalid`=1 and `arsize={size}`. The `cnt` of that ID is incremented.
- **Write accept.**
  - `wr_busy` is set.
  - `awaddr`, `awsize`, `wdata` and `wstrb` are registered.
  - `awvalid` and `wvalid` are both set to 1.
  - Each valid drops independently on its own ready handshake.
- **R channel.**
  - `rready`=1 whenever out of reset.
  - On `rvalid` with `rid`∈{0,1} and `cnt[rid]`>0: register `rdata` into that port's `rdata`, pulse that port's `data_ok` on the next cycle, and decrement `cnt[rid]`.
  - Any other `rid`, or a response while the counter is 0, is dropped with no pulse.
- **B channel.**
  - `bready`=1 whenever out of reset.
  - On `bvalid` with `wr_busy`: clear `wr_busy` and pulse `data_data_ok` on the next cycle.
  - A stray `bvalid` while not busy is ignored.
- **Counters.** An increment and decrement on the same edge leave the count unchanged. A counter never exceeds `MAX_RD` and never wraps below 0.
- **Within-ID ordering.** The AXI slave returns data in order within each ID, so no reorder buffer is needed.

## Timing
- **Reset values.**
  - 0: all valids, `*_addr_ok`, `*_data_ok`, `rready`, `bready`, counters, `wr_busy`.
  - 0: `araddr`, `awaddr`, `arsize`, `awsize`, `wdata`, `wstrb`, `*_rdata`.
  - Constant-tied outputs hold their tie values at all times.
- **Reset mid-operation.** All state is cleared and in-flight AXI transactions are abandoned; their late responses fall under the cnt==0 / ~wr_busy drop rules.
- **Latency.**
  - `addr_ok` handshake to `arvalid`: 1 cycle.
  - R handshake to `data_ok`: 1 cycle.
  - B handshake to `data_data_ok`: 1 cycle.
  - Minimum read round trip with `arready`=1 and a 1-cycle slave: 3 cycles.
- **Throughput.** One AR issue per cycle is sustained when `arready` stays high.
- **Hold rule.** `arvalid`/`awvalid`/`wvalid`, once high, hold with stable payload until their ready is seen.
- **Combinational paths.** `addr_ok` depends combinationally on `arready`. No other input-to-output combinational paths exist.

## Test plan
- **Back-to-back fetches.** `arready`=1 and rvalid 1 cycle after AR; inst reads to 0x0, 0x4, 0x8, 0xC on consecutive cycles → 4 AR beats with `arid`=0 on consecutive cycles; 4 `inst_data_ok` pulses with the matching rdata.
- **Outstanding cap.** `MAX_RD`=4 and rvalid withheld; 6 inst requests → exactly 4 are accepted and `inst_addr_ok`=0 afterward. One R beat → one further request is accepted the following cycle.
- **Arbitration and out-of-order IDs.** Inst and data reads issued in the same cycle → data issued first (`arid`=1) and inst the next cycle. Slave returns ID 0 before ID 1 → pulses arrive on the correct ports with the correct data.
- **Write with split readies.** Write 0xDEADBEEF, strb 0xF, to 0x100; `awready` at cycle 1 and `wready` at cycle 4 → `awvalid` drops after cycle 1 and `wvalid` holds until cycle 4. `data_data_ok` pulses 1 cycle after `bvalid`.
- **RAW guard.** While a write to 0x100 awaits B, an inst read to 0x100 → `inst_addr_ok`=0. Inst read to 0x104 → accepted. Data read to 0x200 → blocked until B arrives.
- **Reset mid-flight.** Reset asserted with 2 reads outstanding, then the 2 R beats arrive → no `data_ok` pulses and the counters stay 0.

Source files
------------

// File: rtl/sram_axi_bridge_mo.sv
// rtl/sram_axi_bridge_mo.sv - two SRAM-like ports (inst read-only, data read/write) onto one AXI3 master.
// One AR slot shared by both ports, per-ID outstanding counters, single outstanding write.
module sram_axi_bridge_mo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_RD = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_inst_req,
  input  logic                i_inst_wr,
  input  logic [2:0]          i_inst_size,
  input  logic [DATA_W/8-1:0] i_inst_wstrb,
  input  logic [ADDR_W-1:0]   i_inst_addr,
  input  logic [DATA_W-1:0]   i_inst_wdata,
  output logic [DATA_W-1:0]   o_inst_rdata,
  output logic                o_inst_addr_ok,
  output logic                o_inst_data_ok,
  input  logic                i_data_req,
  input  logic                i_data_wr,
  input  logic [2:0]          i_data_size,
  input  logic [DATA_W/8-1:0] i_data_wstrb,
  input  logic [ADDR_W-1:0]   i_data_addr,
  input  logic [DATA_W-1:0]   i_data_wdata,
  output logic [DATA_W-1:0]   o_data_rdata,
  output logic                o_data_addr_ok,
  output logic                o_data_data_ok,
  output logic [3:0]          o_arid,
  output logic [ADDR_W-1:0]   o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic [1:0]          o_arlock,
  output logic [3:0]          o_arcache,
  output logic [2:0]          o_arprot,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [3:0]          i_rid,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready,
  output logic [3:0]          o_awid,
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic [1:0]          o_awlock,
  output logic [3:0]          o_awcache,
  output logic [2:0]          o_awprot,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [3:0]          o_wid,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [3:0]          i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);
  localparam int CW = $clog2(MAX_RD + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_RD);

  logic                r_arvalid, r_awvalid, r_wvalid, r_wr_busy, r_rdy;
  logic [3:0]          r_arid;
  logic [ADDR_W-1:0]   r_araddr, r_awaddr;
  logic [2:0]          r_arsize, r_awsize;
  logic [DATA_W-1:0]   r_wdata, r_inst_rdata, r_data_rdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [CW-1:0]       r_cnt0, r_cnt1;
  logic                r_inst_data_ok, r_data_data_ok;

  logic w_slot_free, w_raw_hit, w_data_rd_ok, w_data_wr_ok, w_inst_ok;
  logic w_r_hit0, w_r_hit1, w_b_hit, w_unused;

  assign w_slot_free  = ~r_arvalid | i_arready;
  assign w_raw_hit    = r_wr_busy & (i_inst_addr[ADDR_W-1:2] == r_awaddr[ADDR_W-1:2]);
  assign w_data_rd_ok = ~i_reset & i_data_req & ~i_data_wr & w_slot_free & (r_cnt1 < MAX_C) & ~r_wr_busy;
  // Data read outranks an instruction fetch for the single AR slot.
  assign w_inst_ok    = ~i_reset & i_inst_req & ~i_inst_wr & w_slot_free & (r_cnt0 < MAX_C)
                        & ~w_raw_hit & ~w_data_rd_ok;
  assign w_data_wr_ok = ~i_reset & i_data_req & i_data_wr & ~r_wr_busy & (r_cnt1 == '0)
                        & ~(r_arvalid & (r_arid == 4'd1));

  assign w_r_hit0 = r_rdy & i_rvalid & (i_rid == 4'd0) & (r_cnt0 != '0);
  assign w_r_hit1 = r_rdy & i_rvalid & (i_rid == 4'd1) & (r_cnt1 != '0);
  assign w_b_hit  = r_rdy & i_bvalid & r_wr_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arsize  <= '0;
    end else if (w_data_rd_ok | w_inst_ok) begin
      r_arvalid <= 1'b1;
      r_arid    <= w_data_rd_ok ? 4'd1 : 4'd0;
      r_araddr  <= w_data_rd_ok ? i_data_addr : i_inst_addr;
      r_arsize  <= w_data_rd_ok ? i_data_size : i_inst_size;
    end else if (i_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_inst_ok & ~w_r_hit0)      r_cnt0 <= r_cnt0 + CW'(1);
      else if (~w_inst_ok & w_r_hit0) r_cnt0 <= r_cnt0 - CW'(1);
      if (w_data_rd_ok & ~w_r_hit1)      r_cnt1 <= r_cnt1 + CW'(1);
      else if (~w_data_rd_ok & w_r_hit1) r_cnt1 <= r_cnt1 - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_busy <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_awsize  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_data_wr_ok) begin
      r_wr_busy <= 1'b1;
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_awaddr  <= i_data_addr;
      r_awsize  <= i_data_size;
      r_wdata   <= i_data_wdata;
      r_wstrb   <= i_data_wstrb;
    end else begin
      if (w_b_hit)   r_wr_busy <= 1'b0;
      if (i_awready) r_awvalid <= 1'b0;
      if (i_wready)  r_wvalid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdy          <= 1'b0;
      r_inst_rdata   <= '0;
      r_data_rdata   <= '0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
    end else begin
      r_rdy          <= 1'b1;
      r_inst_data_ok <= w_r_hit0;
      r_data_data_ok <= w_r_hit1 | w_b_hit;
      if (w_r_hit0) r_inst_rdata <= i_rdata;
      if (w_r_hit1) r_data_rdata <= i_rdata;
    end
  end

  assign o_inst_rdata   = r_inst_rdata;
  assign o_inst_addr_ok = w_inst_ok;
  assign o_inst_data_ok = r_inst_data_ok;
  assign o_data_rdata   = r_data_rdata;
  assign o_data_addr_ok = w_data_rd_ok | w_data_wr_ok;
  assign o_data_data_ok = r_data_data_ok;
  assign o_arid    = r_arid;
  assign o_araddr  = r_araddr;
  assign o_arlen   = 8'd0;
  assign o_arsize  = r_arsize;
  assign o_arburst = 2'b01;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'd0;
  assign o_arprot  = 3'd0;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rdy;
  assign o_awid    = 4'd1;
  assign o_awaddr  = r_awaddr;
  assign o_awlen   = 8'd0;
  assign o_awsize  = r_awsize;
  assign o_awburst = 2'b01;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'd0;
  assign o_awprot  = 3'd0;
  assign o_awvalid = r_awvalid;
  assign o_wid     = 4'd1;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_rdy;

  assign w_unused = ^{i_inst_wstrb, i_inst_wdata, i_rresp, i_rlast, i_bid, i_bresp};
endmodule

// File: tb/tb_sram_axi_bridge_mo.sv
// tb/tb_sram_axi_bridge_mo.sv - directed self-checking bench for sram_axi_bridge_mo.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_sram_axi_bridge_mo;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [2:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_axi_bridge_mo #(.ADDR_W(32), .DATA_W(32), .MAX_RD(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_inst_req(inst_req), .i_inst_wr(inst_wr), .i_inst_size(inst_size), .i_inst_wstrb(inst_wstrb),
    .i_inst_addr(inst_addr), .i_inst_wdata(inst_wdata), .o_inst_rdata(inst_rdata),
    .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok),
    .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size), .i_data_wstrb(data_wstrb),
    .i_data_addr(data_addr), .i_data_wdata(data_wdata), .o_data_rdata(data_rdata),
    .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot), .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot), .o_awvalid(awvalid), .i_awready(awready),
    .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready)
  );

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 3'd2; inst_wstrb = 4'hF; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 3'd2; data_wstrb = 4'hF; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    @(negedge clk); @(negedge clk);
    inst_req = 1; data_req = 1;
    #1;
    checks++; if (arvalid !== 0 || awvalid !== 0 || wvalid !== 0) begin failures++;
      $display("FAIL reset_valids got=%b%b%b exp=000", arvalid, awvalid, wvalid); end
    checks++; if (inst_addr_ok !== 0 || data_addr_ok !== 0 || rready !== 0 || bready !== 0) begin failures++;
      $display("FAIL reset_handshake got=%b%b%b%b exp=0000", inst_addr_ok, data_addr_ok, rready, bready); end
    checks++; if (araddr !== 0 || awaddr !== 0 || wdata !== 0 || wstrb !== 0 || inst_rdata !== 0 || data_rdata !== 0) begin
      failures++; $display("FAIL reset_payload got=%h/%h/%h exp=0", araddr, awaddr, wdata); end
    checks++; if (arburst !== 2'b01 || awid !== 4'd1 || wid !== 4'd1 || wlast !== 1 || arlen !== 0) begin failures++;
      $display("FAIL reset_ties got=%b/%h/%h/%b exp=01/1/1/1", arburst, awid, wid, wlast); end
    idle_inputs(); reset = 0;
    @(negedge clk); #1;
    checks++; if (rready !== 1 || bready !== 1) begin failures++;
      $display("FAIL ready_after_reset got=%b%b exp=11", rready, bready); end
  endtask

  task automatic test_back_to_back();
    arready = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      inst_req = (i < 4); inst_addr = 32'(4 * i);
      rvalid = (i >= 2 && i <= 5); rid = 0; rdata = 32'hA000_0000 | 32'(i - 2);
      #1;
      checks++; if (inst_addr_ok !== (i < 4)) begin failures++;
        $display("FAIL b2b_addr_ok[%0d] got=%b exp=%b", i, inst_addr_ok, (i < 4)); end
      checks++; if (arvalid !== (i >= 1 && i <= 4)) begin failures++;
        $display("FAIL b2b_arvalid[%0d] got=%b", i, arvalid); end
      if (i >= 1 && i <= 4) begin
        checks++; if (araddr !== 32'(4 * (i - 1)) || arid !== 0) begin failures++;
          $display("FAIL b2b_ar[%0d] got=%h id=%h exp=%h id=0", i, araddr, arid, 4 * (i - 1)); end
      end
      checks++; if (inst_data_ok !== (i >= 3)) begin failures++;
        $display("FAIL b2b_data_ok[%0d] got=%b exp=%b", i, inst_data_ok, (i >= 3)); end
      if (i >= 3) begin
        checks++; if (inst_rdata !== (32'hA000_0000 | 32'(i - 3))) begin failures++;
          $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, inst_rdata, 32'hA000_0000 | 32'(i - 3)); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_outstanding_cap();
    arready = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h40 + 32'(4 * i);
      rvalid = (i == 6); rid = 0; rdata = 32'hC0FF_EE00;
      #1;
      checks++; if (inst_addr_ok !== (i < 4 || i == 7)) begin failures++;
        $display("FAIL cap_addr_ok[%0d] got=%b exp=%b", i, inst_addr_ok, (i < 4 || i == 7)); end
      if (i == 7) begin
        checks++; if (inst_data_ok !== 1 || inst_rdata !== 32'hC0FF_EE00) begin failures++;
          $display("FAIL cap_beat got=%b/%h exp=1/c0ffee00", inst_data_ok, inst_rdata); end
      end
    end
    inst_req = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      rvalid = (j < 4 || j == 5); rid = 0; rdata = 32'(j);
      #1;
      checks++; if (inst_data_ok !== (j >= 1 && j <= 4)) begin failures++;
        $display("FAIL cap_drain[%0d] got=%b exp=%b", j, inst_data_ok, (j >= 1 && j <= 4)); end
    end
    idle_inputs();
  endtask

  task automatic test_arbitration();
    arready = 1;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h300; data_req = 1; data_wr = 0; data_addr = 32'h400; data_size = 3'd1;
    #1;
    checks++; if (data_addr_ok !== 1 || inst_addr_ok !== 0) begin failures++;
      $display("FAIL arb_win got=d%b i%b exp=d1 i0", data_addr_ok, inst_addr_ok); end
    @(negedge clk); data_req = 0; #1;
    checks++; if (arvalid !== 1 || arid !== 1 || araddr !== 32'h400 || arsize !== 3'd1 || inst_addr_ok !== 1) begin
      failures++; $display("FAIL arb_first got=id%h %h sz%0d ok%b exp=id1 400 sz1 ok1", arid, araddr, arsize, inst_addr_ok); end
    @(negedge clk); inst_req = 0; #1;
    checks++; if (arvalid !== 1 || arid !== 0 || araddr !== 32'h300) begin failures++;
      $display("FAIL arb_second got=id%h %h exp=id0 300", arid, araddr); end
    @(negedge clk); rvalid = 1; rid = 0; rdata = 32'h1111_1111; #1;
    @(negedge clk); rid = 1; rdata = 32'h2222_2222; #1;
    checks++; if (inst_data_ok !== 1 || inst_rdata !== 32'h1111_1111 || data_data_ok !== 0) begin failures++;
      $display("FAIL arb_id0 got=%b/%h/%b exp=1/11111111/0", inst_data_ok, inst_rdata, data_data_ok); end
    @(negedge clk); rvalid = 0; #1;
    checks++; if (data_data_ok !== 1 || data_rdata !== 32'h2222_2222 || inst_data_ok !== 0) begin failures++;
      $display("FAIL arb_id1 got=%b/%h/%b exp=1/22222222/0", data_data_ok, data_rdata, inst_data_ok); end
    idle_inputs();
  endtask

  task automatic test_write_split();
    @(negedge clk);
    data_req = 1; data_wr = 1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
    #1;
    checks++; if (data_addr_ok !== 1) begin failures++;
      $display("FAIL wr_accept got=%b exp=1", data_addr_ok); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      data_req = 0; data_wr = 0; awready = (i == 1); wready = (i == 4);
      #1;
      checks++; if (awvalid !== (i == 1) || wvalid !== (i <= 4)) begin failures++;
        $display("FAIL wr_valids[%0d] got=aw%b w%b exp=aw%b w%b", i, awvalid, wvalid, (i == 1), (i <= 4)); end
      checks++; if (awaddr !== 32'h100 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF || data_data_ok !== 0) begin
        failures++; $display("FAIL wr_payload[%0d] got=%h/%h/%h/%b", i, awaddr, wdata, wstrb, data_data_ok); end
    end
    idle_inputs();
  endtask

  task automatic test_raw_guard();
    arready = 1;
    @(negedge clk); inst_req = 1; inst_addr = 32'h100; #1;
    checks++; if (inst_addr_ok !== 0) begin failures++;
      $display("FAIL raw_same_word got=%b exp=0", inst_addr_ok); end
    @(negedge clk); inst_addr = 32'h104; #1;
    checks++; if (inst_addr_ok !== 1) begin failures++;
      $display("FAIL raw_next_word got=%b exp=1", inst_addr_ok); end
    @(negedge clk); inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h200; #1;
    checks++; if (data_addr_ok !== 0 || arvalid !== 1 || araddr !== 32'h104) begin failures++;
      $display("FAIL raw_data_blocked got=%b ar=%b %h exp=0 1 104", data_addr_ok, arvalid, araddr); end
    @(negedge clk); rvalid = 1; rid = 0; rdata = 32'h5555_5555; bvalid = 1; #1;
    checks++; if (data_addr_ok !== 0) begin failures++;
      $display("FAIL raw_blocked_at_b got=%b exp=0", data_addr_ok); end
    @(negedge clk); rvalid = 0; bvalid = 0; #1;
    checks++; if (data_data_ok !== 1 || inst_data_ok !== 1 || inst_rdata !== 32'h5555_5555 || data_addr_ok !== 1) begin
      failures++; $display("FAIL raw_after_b got=d%b i%b %h ok%b exp=1 1 55555555 1", data_data_ok, inst_data_ok, inst_rdata, data_addr_ok); end
    @(negedge clk); data_req = 0; #1;
    checks++; if (arvalid !== 1 || arid !== 1 || araddr !== 32'h200 || data_data_ok !== 0) begin failures++;
      $display("FAIL raw_data_ar got=%b id%h %h ok%b exp=1 id1 200 0", arvalid, arid, araddr, data_data_ok); end
    @(negedge clk); rvalid = 1; rid = 1; rdata = 32'h6666_6666; #1;
    @(negedge clk); rvalid = 0; bvalid = 1; #1;
    checks++; if (data_data_ok !== 1 || data_rdata !== 32'h6666_6666) begin failures++;
      $display("FAIL raw_data_rd got=%b/%h exp=1/66666666", data_data_ok, data_rdata); end
    @(negedge clk); bvalid = 0; #1;
    checks++; if (data_data_ok !== 0) begin failures++;
      $display("FAIL stray_b got=%b exp=0", data_data_ok); end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    arready = 1;
    @(negedge clk); data_req = 1; data_addr = 32'h500; #1;
    @(negedge clk); data_req = 0; inst_req = 1; inst_addr = 32'h600; #1;
    @(negedge clk); inst_req = 0; #1;
    @(negedge clk); reset = 1; #1;
    @(negedge clk); reset = 0; #1;
    checks++; if (arvalid !== 0 || rready !== 0) begin failures++;
      $display("FAIL mid_reset_state got=%b%b exp=00", arvalid, rready); end
    @(negedge clk); rvalid = 1; rid = 0; rdata = 32'h7777_7777; #1;
    @(negedge clk); rid = 1; rdata = 32'h8888_8888; #1;
    checks++; if (inst_data_ok !== 0) begin failures++;
      $display("FAIL mid_drop_id0 got=%b exp=0", inst_data_ok); end
    @(negedge clk); rvalid = 0; data_req = 1; data_wr = 1; data_addr = 32'h700; #1;
    checks++; if (data_data_ok !== 0 || inst_data_ok !== 0) begin failures++;
      $display("FAIL mid_drop_id1 got=%b%b exp=00", data_data_ok, inst_data_ok); end
    checks++; if (data_addr_ok !== 1) begin failures++;
      $display("FAIL mid_cnt1_zero got=%b exp=1", data_addr_ok); end
    @(negedge clk); idle_inputs(); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_outstanding_cap();
    test_arbitration();
    test_write_split();
    test_raw_guard();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
